adaptive_route_planner: RTL and testbench
=========================================

# adaptive_route_planner

Registered, parametrised route planner for one input link controller of the mesh router. It latches the header fields of an arriving packet and computes the productive output set using XY or West-First minimal routing. It appends the processing-element request internally and selects one output per arbitration round, congestion-aware with round-robin fairness. It holds that request until granted, re-selects after a configurable timeout, and keeps the granted port until the packet releases it.

## Interface
- PORT_DIR, `X_POS — input port this planner serves (`PE, `X_POS, `Y_POS, `X_NEG, `Y_NEG).
- X_LOCAL, 1 — node x coordinate.
- Y_LOCAL, 1 — node y coordinate.
- X_WIDTH, 2 — width of x_field_din.
- Y_WIDTH, 2 — width of y_field_din.
- ALGO, "WF" — "XY" (dimension-ordered) or "WF" (west-first minimal); any other value behaves as "WF".
- RETRY_CYCLES, 8 — cycles without grant before re-selection; 0 disables re-selection.

Ports; output vectors are indexed by absolute port: [0]=PE, [1]=X+, [2]=Y+, [3]=X-, [4]=Y-.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- header_valid_din  in  1  header flit fields valid this cycle.
- done_field_din  in  1  packet already processed (0 = still needs a PE).
- x_field_din  in  X_WIDTH  destination x.
- y_field_din  in  Y_WIDTH  destination y.
- busy_din  in  5  downstream output unavailable.
- grant_din  in  5  grant from output arbiters.
- release_din  in  1  tail flit forwarded; frees the route.
- request_vector_dout  out  5  one-hot (or zero) request.
- port_active_dout  out  5  one-hot granted port while the route is held.
- planner_busy_dout  out  1  state is not IDLE.

## Operation
- Candidate set C, computed from the latched fields; the bit of PORT_DIR is always forced to 0.
  - Arrived (x==X_LOCAL and y==Y_LOCAL): C = {PE}.
  - "XY": x dest > local gives X+, x dest < local gives X-. If x is equal, y dest > local gives Y+ and y dest < local gives Y-.
  - "WF": x dest < local gives {X-} only. Otherwise C holds X+ if x dest > local, plus Y+/Y- as productive.
  - done_field=0 and not arrived: PE is added to C.
- Selection, registered:
  - If PE is in C, PE is not busy, and done=0, select PE.
  - Otherwise select the first non-busy member of C, scanning upward from round-robin pointer ptr with wrap-around.
  - If every member of C is busy, select none.
- FSM states and transitions:
  - IDLE: outputs zero. On header_valid_din, latch the fields, evaluate selection, and go to REQ.
  - REQ, request nonzero: request_vector_dout holds the selected bit steady.
    - grant_din on the requested bit: go to ACTIVE, port_active_dout = that bit, ptr = granted index + 1 mod 5.
    - Grant on an unrequested bit: ignored.
  - REQ, request zero: re-evaluate selection every cycle until a candidate frees.
  - REQ, retry: the retry counter counts cycles in REQ with a nonzero request and no grant.
    - When it reaches RETRY_CYCLES (nonzero), re-select excluding the current bit. If no alternative is non-busy, keep the current bit.
    - The counter clears in either case.
  - ACTIVE: request is 0 and port_active_dout is held. release_din goes to IDLE.
- header_valid_din outside IDLE is ignored, including a header in the same cycle as release_din.
- Retry counter width: $clog2(RETRY_CYCLES+1), saturating; never wraps.

## Timing
- Reset (synchronous): state=IDLE, request_vector_dout=0, port_active_dout=0, planner_busy_dout=0, ptr=0, counter=0, latched fields=0; all apply on the next clk edge.
- Reset asserted mid-REQ or mid-ACTIVE aborts the route. Outputs are 0 the cycle after the edge.
- Header to request latency: header_valid_din at edge t gives the request visible after t+1.
- Grant at edge n gives request=0 and port_active_dout set after n+1.
- Release at edge r gives port_active_dout=0 and IDLE after r+1. The earliest new header is accepted at edge r+1.
- Retry: with continuous busy on alternatives absent, the request changes exactly RETRY_CYCLES cycles after it first appeared.
- busy_din affects only selection instants (entry to REQ, a zero-request REQ, retry). A held request is never withdrawn because of busy.

## Test plan
- XY, PORT_DIR=`X_NEG, local (1,1), dest (3,0), done=1 -> request 5'b00010 (X+) one cycle after header; grant[1] -> port_active 5'b00010; release -> all zero.
- WF, PORT_DIR=`Y_NEG, dest (2,2), done=1, busy=5'b00010, ptr=0 -> request 5'b00100 (Y+); no grant for RETRY_CYCLES=8 with busy cleared -> request switches to 5'b00010 at cycle 9.
- done=0, dest (0,1), PE not busy -> request 5'b00001; with busy[0]=1 -> request 5'b01000 (X-).
- Arrived (1,1), done=1, PORT_DIR=`PE -> C empty after masking, request stays 0, state REQ, planner_busy=1.
- All candidates busy -> request 0; busy clears at cycle k -> request appears at k+1; spurious grant[4] while requesting X+ -> ignored.
- Reset asserted during ACTIVE -> all outputs 0 next cycle; header in the same cycle as release -> ignored, planner returns to IDLE.

Source files
------------

// File: rtl/adaptive_route_planner.sv
// adaptive_route_planner: latches a packet header and derives the productive
// output set (XY or west-first). It requests one output at a time, preferring
// the local PE and otherwise scanning round-robin past busy outputs. A request
// is held until it is granted and moves to an alternative after a timeout.
// The granted port is then held until the tail flit releases the route.

`ifndef PE
`define PE    0
`endif
`ifndef X_POS
`define X_POS 1
`endif
`ifndef Y_POS
`define Y_POS 2
`endif
`ifndef X_NEG
`define X_NEG 3
`endif
`ifndef Y_NEG
`define Y_NEG 4
`endif

module adaptive_route_planner #(
    parameter int PORT_DIR     = `X_POS,
    parameter int X_LOCAL      = 1,
    parameter int Y_LOCAL      = 1,
    parameter int X_WIDTH      = 2,
    parameter int Y_WIDTH      = 2,
    parameter     ALGO         = "WF",
    parameter int RETRY_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               header_valid_din,
    input  logic               done_field_din,
    input  logic [X_WIDTH-1:0] x_field_din,
    input  logic [Y_WIDTH-1:0] y_field_din,
    input  logic [4:0]         busy_din,
    input  logic [4:0]         grant_din,
    input  logic               release_din,
    output logic [4:0]         request_vector_dout,
    output logic [4:0]         port_active_dout,
    output logic               planner_busy_dout
);

    // Anything other than "XY" falls back to west-first routing.
    localparam bit IS_XY = (ALGO == "XY");

    localparam logic [X_WIDTH-1:0] X_HERE = X_WIDTH'(X_LOCAL);
    localparam logic [Y_WIDTH-1:0] Y_HERE = Y_WIDTH'(Y_LOCAL);

    // A packet never turns back out of the port it arrived on.
    localparam logic [4:0] DIR_MASK = ~(5'b00001 << PORT_DIR);

    // The counter is kept one bit wide when the timeout is disabled so that it never has zero width.
    localparam int               CNT_W     = (RETRY_CYCLES > 0) ? $clog2(RETRY_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   RETRY_LIM = (CNT_W + 1)'(RETRY_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACTIVE
    } state_t;

    state_t             state_q;
    logic [4:0]         request_q;
    logic [4:0]         portActive_q;
    logic               plannerBusy_q;
    logic [2:0]         ptr_q;
    logic [CNT_W-1:0]   retryCnt_q;
    logic [X_WIDTH-1:0] xField_q;
    logic [Y_WIDTH-1:0] yField_q;
    logic               done_q;

    logic [4:0]         candEntry;
    logic [4:0]         candHeld;
    logic [4:0]         selEntry;
    logic [4:0]         selHeld;
    logic [4:0]         selAlt;
    logic               grantHit;
    logic [2:0]         grantIdx;
    logic [2:0]         nextPtr;
    logic [CNT_W:0]     cntNext;
    logic               retryFire;

    // Productive output set for a destination, with the PE appended while work is pending.
    function automatic logic [4:0] candidates(input logic [X_WIDTH-1:0] x,
                                              input logic [Y_WIDTH-1:0] y,
                                              input logic               done);
        logic [4:0] c;
        logic       arrived;
        c       = '0;
        arrived = (x == X_HERE) && (y == Y_HERE);
        if (arrived) begin
            c[0] = 1'b1;
        end else if (IS_XY) begin
            if (x > X_HERE) begin
                c[1] = 1'b1;
            end else if (x < X_HERE) begin
                c[3] = 1'b1;
            end else if (y > Y_HERE) begin
                c[2] = 1'b1;
            end else begin
                c[4] = 1'b1;
            end
        end else if (x < X_HERE) begin
            c[3] = 1'b1;
        end else begin
            c[1] = (x > X_HERE);
            c[2] = (y > Y_HERE);
            c[4] = (y < Y_HERE);
        end
        if (!done && !arrived) begin
            c[0] = 1'b1;
        end
        return c & DIR_MASK;
    endfunction

    // PE first when it still needs the packet, else the first free candidate at or after ptr.
    function automatic logic [4:0] pick(input logic [4:0] c,
                                        input logic [4:0] busy,
                                        input logic       done,
                                        input logic [2:0] ptr);
        logic [4:0] sel;
        logic [4:0] free;
        logic [3:0] sum;
        logic [2:0] idx;
        sel  = '0;
        free = c & ~busy;
        if (free[0] && !done) begin
            sel = 5'b00001;
        end else begin
            // Walk from the farthest offset down so the nearest free port is written last.
            for (int i = 4; i >= 0; i--) begin
                sum = {1'b0, ptr} + 4'(i);
                if (sum >= 4'd5) begin
                    sum = sum - 4'd5;
                end
                idx = sum[2:0];
                if (free[idx]) begin
                    sel = 5'b00001 << idx;
                end
            end
        end
        return sel;
    endfunction

    // Selection candidates for entry, idle re-evaluation and timeout, plus grant and retry decode.
    always_comb begin
        candEntry = candidates(x_field_din, y_field_din, done_field_din);
        candHeld  = candidates(xField_q, yField_q, done_q);
        selEntry  = pick(candEntry, busy_din, done_field_din, ptr_q);
        selHeld   = pick(candHeld, busy_din, done_q, ptr_q);
        selAlt    = pick(candHeld & ~request_q, busy_din, done_q, ptr_q);
        grantHit  = |(grant_din & request_q);
        grantIdx  = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (request_q[i]) begin
                grantIdx = 3'(i);
            end
        end
        nextPtr   = (grantIdx == 3'd4) ? 3'd0 : grantIdx + 3'd1;
        cntNext   = {1'b0, retryCnt_q} + 1'b1;
        retryFire = (RETRY_CYCLES != 0) && (request_q != 5'b00000) && (cntNext >= RETRY_LIM);
    end

    // Route planner state machine; every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            request_q     <= '0;
            portActive_q  <= '0;
            plannerBusy_q <= 1'b0;
            ptr_q         <= '0;
            retryCnt_q    <= '0;
            xField_q      <= '0;
            yField_q      <= '0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (header_valid_din) begin
                        xField_q      <= x_field_din;
                        yField_q      <= y_field_din;
                        done_q        <= done_field_din;
                        request_q     <= selEntry;
                        plannerBusy_q <= 1'b1;
                        retryCnt_q    <= '0;
                        state_q       <= REQ;
                    end
                end
                REQ: begin
                    if (grantHit) begin
                        portActive_q <= request_q;
                        request_q    <= '0;
                        ptr_q        <= nextPtr;
                        retryCnt_q   <= '0;
                        state_q      <= ACTIVE;
                    end else if (request_q == 5'b00000) begin
                        request_q  <= selHeld;
                        retryCnt_q <= '0;
                    end else if (retryFire) begin
                        if (selAlt != 5'b00000) begin
                            request_q <= selAlt;
                        end
                        retryCnt_q <= '0;
                    end else if (retryCnt_q != CNT_MAX) begin
                        retryCnt_q <= retryCnt_q + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (release_din) begin
                        portActive_q  <= '0;
                        plannerBusy_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    request_q     <= '0;
                    portActive_q  <= '0;
                    plannerBusy_q <= 1'b0;
                end
            endcase
        end
    end

    assign request_vector_dout = request_q;
    assign port_active_dout    = portActive_q;
    assign planner_busy_dout   = plannerBusy_q;

endmodule

// File: tb/tb_adaptive_route_planner.sv
// tb_adaptive_route_planner: three planners sharing one stimulus stream.
// u0 is WF on Y-, u1 is XY on X-, and u2 serves the PE with an unknown
// algorithm name and the timeout disabled. A behavioural route model runs
// beside them. It is followed by directed scenarios and a randomized phase.

module tb_adaptive_route_planner;

    localparam int         NI         = 3;
    localparam int         P_DIR[NI]  = '{4, 3, 0};
    localparam bit         P_XY[NI]   = '{1'b0, 1'b1, 1'b0};
    localparam int         P_RETRY[NI]= '{8, 8, 0};

    logic       clk;
    logic       rst;
    logic       hv;
    logic       doneIn;
    logic [1:0] xIn;
    logic [1:0] yIn;
    logic [4:0] busyIn;
    logic [4:0] grantIn;
    logic       relIn;

    logic [4:0] reqOut [NI];
    logic [4:0] actOut [NI];
    logic       pbOut  [NI];

    int testsRun;
    int testsFailed;
    bit modelLive;

    // Model state: 0 idle, 1 requesting, 2 holding a port; -1 means no port.
    int mState [NI];
    int mX     [NI];
    int mY     [NI];
    bit mDone  [NI];
    int mPtr   [NI];
    int mReq   [NI];
    int mAct   [NI];
    int mWait  [NI];

    adaptive_route_planner #(
        .PORT_DIR(4), .X_LOCAL(1), .Y_LOCAL(1), .X_WIDTH(2), .Y_WIDTH(2),
        .ALGO("WF"), .RETRY_CYCLES(8)
    ) u0 (
        .clk(clk), .reset(rst), .header_valid_din(hv), .done_field_din(doneIn),
        .x_field_din(xIn), .y_field_din(yIn), .busy_din(busyIn), .grant_din(grantIn),
        .release_din(relIn), .request_vector_dout(reqOut[0]),
        .port_active_dout(actOut[0]), .planner_busy_dout(pbOut[0])
    );

    adaptive_route_planner #(
        .PORT_DIR(3), .X_LOCAL(1), .Y_LOCAL(1), .X_WIDTH(2), .Y_WIDTH(2),
        .ALGO("XY"), .RETRY_CYCLES(8)
    ) u1 (
        .clk(clk), .reset(rst), .header_valid_din(hv), .done_field_din(doneIn),
        .x_field_din(xIn), .y_field_din(yIn), .busy_din(busyIn), .grant_din(grantIn),
        .release_din(relIn), .request_vector_dout(reqOut[1]),
        .port_active_dout(actOut[1]), .planner_busy_dout(pbOut[1])
    );

    adaptive_route_planner #(
        .PORT_DIR(0), .X_LOCAL(1), .Y_LOCAL(1), .X_WIDTH(2), .Y_WIDTH(2),
        .ALGO("ZZ"), .RETRY_CYCLES(0)
    ) u2 (
        .clk(clk), .reset(rst), .header_valid_din(hv), .done_field_din(doneIn),
        .x_field_din(xIn), .y_field_din(yIn), .busy_din(busyIn), .grant_din(grantIn),
        .release_din(relIn), .request_vector_dout(reqOut[2]),
        .port_active_dout(actOut[2]), .planner_busy_dout(pbOut[2])
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output set a destination may legally use, from the routing rules.
    function automatic logic [4:0] mCand(input int k, input int x, input int y, input bit done);
        logic [4:0] c;
        bit         arrived;
        c       = '0;
        arrived = (x == 1) && (y == 1);
        if (arrived) c[0] = 1'b1;
        else if (P_XY[k]) begin
            if (x > 1)      c[1] = 1'b1;
            else if (x < 1) c[3] = 1'b1;
            else if (y > 1) c[2] = 1'b1;
            else            c[4] = 1'b1;
        end else if (x < 1) c[3] = 1'b1;
        else begin
            if (x > 1) c[1] = 1'b1;
            if (y > 1) c[2] = 1'b1;
            if (y < 1) c[4] = 1'b1;
        end
        if (!done && !arrived) c[0] = 1'b1;
        c[P_DIR[k]] = 1'b0;
        return c;
    endfunction

    // Index of the chosen port, or -1 when every candidate is busy.
    function automatic int mPick(input logic [4:0] c, input logic [4:0] busy, input bit done, input int ptr);
        if (c[0] && !busy[0] && !done) return 0;
        for (int i = 0; i < 5; i++) begin
            int p;
            p = (ptr + i) % 5;
            if (c[p] && !busy[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [4:0] expReq(input int k);
        return (mReq[k] >= 0) ? (5'b00001 << mReq[k]) : 5'b00000;
    endfunction

    function automatic logic [4:0] expAct(input int k);
        return (mAct[k] >= 0) ? (5'b00001 << mAct[k]) : 5'b00000;
    endfunction

    task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the behavioural model by one clock edge using the inputs present at that edge.
    task automatic modelStep();
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                mState[k] = 0; mX[k] = 0; mY[k] = 0; mDone[k] = 1'b0;
                mPtr[k] = 0; mReq[k] = -1; mAct[k] = -1; mWait[k] = 0;
            end else if (mState[k] == 0) begin
                if (hv) begin
                    mX[k] = int'(xIn); mY[k] = int'(yIn); mDone[k] = doneIn;
                    mReq[k] = mPick(mCand(k, mX[k], mY[k], mDone[k]), busyIn, mDone[k], mPtr[k]);
                    mWait[k] = 0;
                    mState[k] = 1;
                end
            end else if (mState[k] == 1) begin
                if (mReq[k] >= 0 && grantIn[mReq[k]]) begin
                    mAct[k] = mReq[k];
                    mReq[k] = -1;
                    mPtr[k] = (mAct[k] + 1) % 5;
                    mWait[k] = 0;
                    mState[k] = 2;
                end else if (mReq[k] < 0) begin
                    mReq[k] = mPick(mCand(k, mX[k], mY[k], mDone[k]), busyIn, mDone[k], mPtr[k]);
                    mWait[k] = 0;
                end else begin
                    mWait[k]++;
                    if (P_RETRY[k] != 0 && mWait[k] >= P_RETRY[k]) begin
                        int alt;
                        alt = mPick(mCand(k, mX[k], mY[k], mDone[k]) & ~(5'b00001 << mReq[k]),
                                    busyIn, mDone[k], mPtr[k]);
                        if (alt >= 0) mReq[k] = alt;
                        mWait[k] = 0;
                    end
                end
            end else begin
                if (relIn) begin
                    mAct[k] = -1;
                    mState[k] = 0;
                end
            end
        end
        if (rst) modelLive = 1'b1;
    endtask

    // Step the model on each edge, then compare every planner against it just after the edge.
    always @(posedge clk) begin
        modelStep();
        #1;
        if (modelLive) begin
            for (int k = 0; k < NI; k++) begin
                checkOutput($sformatf("u%0d request", k), reqOut[k], expReq(k));
                checkOutput($sformatf("u%0d port_active", k), actOut[k], expAct(k));
                checkOutput($sformatf("u%0d planner_busy", k), {4'b0000, pbOut[k]},
                            {4'b0000, (mState[k] != 0)});
            end
        end
    end

    // Drive one cycle of inputs at the falling edge and return after the next falling edge.
    task automatic applyStimulus(input bit r, input bit h, input bit d, input int x, input int y,
                                 input logic [4:0] b, input logic [4:0] g, input bit rl);
        rst = r; hv = h; doneIn = d; xIn = 2'(x); yIn = 2'(y);
        busyIn = b; grantIn = g; relIn = rl;
        @(negedge clk);
    endtask

    task automatic idleCycle(input logic [4:0] b);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, b, 5'b00000, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 5'b00000, 5'b00000, 1'b0);
    endtask

    initial begin
        testsRun = 0; testsFailed = 0; modelLive = 1'b0;
        rst = 1'b1; hv = 1'b0; doneIn = 1'b0; xIn = '0; yIn = '0;
        busyIn = '0; grantIn = '0; relIn = 1'b0;

        // Hand-worked pins on the model's routing rules.
        checkOutput("model cand XY (3,0)", mCand(1, 3, 0, 1'b1), 5'b00010);
        checkOutput("model cand WF (2,2)", mCand(0, 2, 2, 1'b1), 5'b00110);
        checkOutput("model cand WF (0,1) pending", mCand(0, 0, 1, 1'b0), 5'b01001);
        checkOutput("model cand arrived at PE port", mCand(2, 1, 1, 1'b1), 5'b00000);
        checkOutput("model pick past busy X+", 5'(mPick(5'b00110, 5'b00010, 1'b1, 0)), 5'd2);

        @(negedge clk);
        doReset();
        doReset();
        checkOutput("reset request", reqOut[0], 5'b00000);
        checkOutput("reset port_active", actOut[0], 5'b00000);
        checkOutput("reset busy", {4'b0000, pbOut[1]}, 5'b00000);

        // XY route east, spurious grant, real grant, release.
        applyStimulus(1'b0, 1'b1, 1'b1, 3, 0, 5'b00000, 5'b00000, 1'b0);
        checkOutput("xy request X+", reqOut[1], 5'b00010);
        checkOutput("xy busy", {4'b0000, pbOut[1]}, 5'b00001);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 5'b00000, 5'b10000, 1'b0);
        checkOutput("xy spurious grant ignored", reqOut[1], 5'b00010);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 5'b00000, 5'b00010, 1'b0);
        checkOutput("xy granted port", actOut[1], 5'b00010);
        checkOutput("xy request after grant", reqOut[1], 5'b00000);
        idleCycle(5'b00000);
        checkOutput("xy port held", actOut[1], 5'b00010);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 5'b00000, 5'b00000, 1'b1);
        checkOutput("xy released", actOut[1], 5'b00000);
        checkOutput("xy idle after release", {4'b0000, pbOut[1]}, 5'b00000);

        // West-first with X+ busy on entry, then timeout moves the request.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 2, 2, 5'b00010, 5'b00000, 1'b0);
        checkOutput("wf request Y+", reqOut[0], 5'b00100);
        for (int i = 1; i < 8; i++) begin
            idleCycle(5'b00000);
            checkOutput($sformatf("wf held cycle %0d", i), reqOut[0], 5'b00100);
        end
        idleCycle(5'b00000);
        checkOutput("wf retry switch", reqOut[0], 5'b00010);
        checkOutput("no retry when disabled", reqOut[2], 5'b00100);
        doReset();
        checkOutput("reset mid-request", reqOut[0], 5'b00000);
        checkOutput("reset mid-request busy", {4'b0000, pbOut[0]}, 5'b00000);

        // Packet still needing the PE.
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 1, 5'b00000, 5'b00000, 1'b0);
        checkOutput("pending picks PE", reqOut[0], 5'b00001);
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 1, 5'b00001, 5'b00000, 1'b0);
        checkOutput("busy PE falls to X-", reqOut[0], 5'b01000);
        checkOutput("only busy PE left", reqOut[1], 5'b00000);
        doReset();

        // Arrived packet on the PE input port: nothing to request.
        applyStimulus(1'b0, 1'b1, 1'b1, 1, 1, 5'b00000, 5'b00000, 1'b0);
        for (int i = 0; i < 3; i++) idleCycle(5'b00000);
        checkOutput("empty set request", reqOut[2], 5'b00000);
        checkOutput("empty set busy", {4'b0000, pbOut[2]}, 5'b00001);
        doReset();

        // All candidates busy, then freed; grant; reset during ACTIVE.
        applyStimulus(1'b0, 1'b1, 1'b1, 3, 1, 5'b11111, 5'b00000, 1'b0);
        checkOutput("all busy request", reqOut[1], 5'b00000);
        idleCycle(5'b11111);
        idleCycle(5'b11111);
        checkOutput("still all busy", reqOut[1], 5'b00000);
        idleCycle(5'b00000);
        checkOutput("request after busy clears", reqOut[1], 5'b00010);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 5'b00000, 5'b10000, 1'b0);
        checkOutput("grant Y- ignored", reqOut[1], 5'b00010);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 5'b00000, 5'b00010, 1'b0);
        checkOutput("granted X+", actOut[1], 5'b00010);
        doReset();
        checkOutput("reset in active port", actOut[1], 5'b00000);
        checkOutput("reset in active busy", {4'b0000, pbOut[1]}, 5'b00000);

        // Header arriving together with release is dropped.
        applyStimulus(1'b0, 1'b1, 1'b1, 3, 0, 5'b00000, 5'b00000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 5'b00000, 5'b00010, 1'b0);
        checkOutput("route held", actOut[1], 5'b00010);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 1, 5'b00000, 5'b00000, 1'b1);
        checkOutput("release with header port", actOut[1], 5'b00000);
        checkOutput("release with header busy", {4'b0000, pbOut[1]}, 5'b00000);
        idleCycle(5'b00000);
        checkOutput("header ignored request", reqOut[1], 5'b00000);
        checkOutput("header ignored busy", {4'b0000, pbOut[1]}, 5'b00000);

        // Randomized traffic; grants mostly aim at a planner's current request.
        for (int c = 0; c < 3000; c++) begin
            bit         r;
            bit         h;
            bit         d;
            bit         rl;
            int         x;
            int         y;
            int         who;
            logic [4:0] b;
            logic [4:0] g;
            r  = ($urandom_range(0, 99) < 2);
            h  = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 1) == 1);
            rl = ($urandom_range(0, 3) == 0);
            x  = int'($urandom_range(0, 3));
            y  = int'($urandom_range(0, 3));
            b  = '0;
            for (int i = 0; i < 5; i++) b[i] = ($urandom_range(0, 99) < 30);
            g   = '0;
            who = int'($urandom_range(0, NI - 1));
            if ($urandom_range(0, 1) == 1) g = expReq(who);
            if ($urandom_range(0, 9) == 0) g = g | (5'b00001 << $urandom_range(0, 4));
            applyStimulus(r, h, d, x, y, b, g, rl);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
